// File: rtl/fb_pkg.sv
// Shared constants, state encoding and helpers for the frame-buffer arbiter.
package fb_pkg;

    localparam int H_START  = 216;
    localparam int H_ACTIVE = 640;
    localparam int V_START  = 35;
    localparam int V_ACTIVE = 480;
    localparam int IMG_COLS = 320;
    localparam int IMG_ROWS = 240;
    localparam int AW       = 17;
    localparam int DW       = 8;
    localparam int COL_W    = 11;
    localparam int ROW_W    = 10;

    // Window bounds sized to the timing counters so compares stay width-clean
    localparam logic [COL_W-1:0] H_FIRST = COL_W'(H_START);
    localparam logic [COL_W-1:0] H_LAST  = COL_W'(H_START + H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] V_FIRST = ROW_W'(V_START);
    localparam logic [ROW_W-1:0] V_LAST  = ROW_W'(V_START + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_WR   = 2'd2
    } arb_state_t;

    // Address is {row[7:0], col[8:0]}; both fields must land inside the 320x240 image
    function automatic logic addr_valid(input logic [AW-1:0] addr);
        return (addr[8:0] < 9'(IMG_COLS)) && (addr[AW-1:9] < 8'(IMG_ROWS));
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Scanout, writer and memory signals seen by the frame-buffer arbiter.
interface fb_arbiter_if;
    import fb_pkg::*;

    logic [ROW_W-1:0] Filas;
    logic [COL_W-1:0] Columnas;
    logic [AW-1:0]    Disp_Addr;
    logic             Wr_Req;
    logic [AW-1:0]    Wr_Addr;
    logic [DW-1:0]    Wr_Data;
    logic             Wr_Ack;
    logic             Wr_Err;
    logic [AW-1:0]    Mem_Addr;
    logic             Mem_We;
    logic [DW-1:0]    Mem_Din;
    logic [DW-1:0]    Mem_Dout;
    logic [DW-1:0]    Pix_Data;
    logic             Pix_Valid;

    // Arbiter side
    modport slave (
        input  Filas, Columnas, Disp_Addr, Wr_Req, Wr_Addr, Wr_Data, Mem_Dout,
        output Wr_Ack, Wr_Err, Mem_Addr, Mem_We, Mem_Din, Pix_Data, Pix_Valid
    );

    // Timing generator / writer / memory side
    modport master (
        output Filas, Columnas, Disp_Addr, Wr_Req, Wr_Addr, Wr_Data, Mem_Dout,
        input  Wr_Ack, Wr_Err, Mem_Addr, Mem_We, Mem_Din, Pix_Data, Pix_Valid
    );

endinterface

// File: rtl/fb_arbiter_disp_slot_gen.sv
// Decodes the timing counters into active-window and display-slot flags.
module disp_slot_gen
    import fb_pkg::*;
(
    input  logic [ROW_W-1:0] Filas,
    input  logic [COL_W-1:0] Columnas,
    output logic             in_window,
    output logic             disp_slot
);

    assign in_window = (Columnas >= H_FIRST) && (Columnas <= H_LAST) &&
                       (Filas >= V_FIRST) && (Filas <= V_LAST);

    // (Columnas - H_START) is even exactly when Columnas and H_START share parity
    assign disp_slot = in_window && (Columnas[0] == H_FIRST[0]);

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: scanout reads win every other active cycle,
// the writer gets the remaining slots, pixels leave through a 3-edge pipeline.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    fb_arbiter_if.slave bus
);

    logic          in_window;
    logic          disp_slot;
    logic          wr_valid;
    arb_state_t    state;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic          mem_we_q;
    logic          wr_ack_q;
    logic          wr_err_q;

    logic          win_d1;
    logic          win_d2;
    logic          disp_d2;
    logic [DW-1:0] pix_data_q;
    logic          pix_valid_q;

    disp_slot_gen u_slot (
        .Filas     (bus.Filas),
        .Columnas  (bus.Columnas),
        .in_window (in_window),
        .disp_slot (disp_slot)
    );

    assign wr_valid = addr_valid(bus.Wr_Addr);

    // Slot arbitration: display slots always win, a write is taken only when
    // the previous cycle did not already acknowledge one.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else if (disp_slot) begin
            state      <= ST_DISP;
            mem_addr_q <= bus.Disp_Addr;
            mem_we_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else if (bus.Wr_Req && !wr_ack_q) begin
            state      <= ST_WR;
            mem_addr_q <= bus.Wr_Addr;
            mem_din_q  <= bus.Wr_Data;
            mem_we_q   <= wr_valid;
            wr_ack_q   <= 1'b1;
            wr_err_q   <= !wr_valid;
        end else begin
            state      <= ST_IDLE;
            mem_we_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end
    end

    // Scanout pipeline: decision -> memory read -> output register. Pix_Data
    // only reloads after a display read, so each memory pixel spans two columns.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            win_d1      <= 1'b0;
            win_d2      <= 1'b0;
            disp_d2     <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            win_d1      <= in_window;
            win_d2      <= win_d1;
            disp_d2     <= (state == ST_DISP);
            pix_valid_q <= win_d2;
            if (disp_d2) begin
                pix_data_q <= bus.Mem_Dout;
            end else if (!win_d2) begin
                pix_data_q <= '0;
            end
        end
    end

    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_Din   = mem_din_q;
    assign bus.Mem_We    = mem_we_q;
    assign bus.Wr_Ack    = wr_ack_q;
    assign bus.Wr_Err    = wr_err_q;
    assign bus.Pix_Data  = pix_data_q;
    assign bus.Pix_Valid = pix_valid_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: pixel and write scoreboards fed from stimulus.
module tb_fb_arbiter;
    import fb_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } pix_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        err;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst;

    fb_arbiter_if bus ();

    fb_arbiter dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Memory model: 1-cycle read latency, content = low address byte + 0x10
    always @(posedge Clk) bus.Mem_Dout <= bus.Mem_Addr[7:0] + 8'h10;

    int errors = 0;
    int checks = 0;
    pix_t pix_q[$];
    wr_t  wr_q[$];
    logic [7:0] last_disp_data = 8'h00;

    function automatic logic tb_win(input int f, input int c);
        return (c >= 216) && (c <= 855) && (f >= 35) && (f <= 514);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive the scanout inputs for one cycle and queue the pixel they should produce
    task automatic drive_scan(input int f, input int c, input logic [16:0] da);
        bus.Filas     = 10'(f);
        bus.Columnas  = 11'(c);
        bus.Disp_Addr = da;
        if (tb_win(f, c)) begin
            if (((c - 216) % 2) == 0) last_disp_data = da[7:0] + 8'h10;
            pix_q.push_back('{valid: 1'b1, data: last_disp_data});
        end else begin
            pix_q.push_back('{valid: 1'b0, data: 8'h00});
        end
    endtask

    task automatic idle(input int n);
        bus.Wr_Req = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_scan(10, 100, 17'd0);
            tick();
        end
        pix_q.delete();
    endtask

    task automatic test_reset();
        logic seen;
        Rst = 1'b1;
        bus.Wr_Req  = 1'b1;
        bus.Wr_Addr = 17'd5;
        bus.Wr_Data = 8'hA5;
        drive_scan(10, 100, 17'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Wr_Ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_ack edge=%0d: got %b want 0", i, bus.Wr_Ack);
            end
        end
        checks++;
        if (bus.Wr_Err !== 1'b0 || bus.Mem_Addr !== 17'd0 || bus.Mem_We !== 1'b0 ||
            bus.Mem_Din !== 8'd0 || bus.Pix_Data !== 8'd0 || bus.Pix_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: err=%b addr=%h we=%b din=%h pix=%h valid=%b want all 0",
                     bus.Wr_Err, bus.Mem_Addr, bus.Mem_We, bus.Mem_Din, bus.Pix_Data, bus.Pix_Valid);
        end
        Rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (bus.Wr_Ack === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.Mem_We !== 1'b1 || bus.Mem_Addr !== 17'd5) begin
            errors++;
            $display("FAIL reset_release_ack: ack_seen=%b we=%b addr=%h want 1 1 00005",
                     seen, bus.Mem_We, bus.Mem_Addr);
        end
        tick();
        bus.Wr_Req = 1'b0;
        tick();
        // reset in the middle of an acknowledged write
        bus.Wr_Req = 1'b1;
        tick();
        checks++;
        if (bus.Wr_Ack !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre_ack: got %b want 1", bus.Wr_Ack);
        end
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (bus.Wr_Ack !== 1'b0 || bus.Mem_We !== 1'b0 || bus.Mem_Addr !== 17'd0) begin
            errors++;
            $display("FAIL midop_async_reset: ack=%b we=%b addr=%h want 0 0 0",
                     bus.Wr_Ack, bus.Mem_We, bus.Mem_Addr);
        end
        tick();
        Rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (bus.Wr_Ack === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midop_rearb: ack_seen=%b want 1 within 2 edges", seen);
        end
        tick();
        bus.Wr_Req = 1'b0;
        tick();
    endtask

    task automatic test_scanout();
        logic [16:0] da;
        pix_t e;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            da = {8'd0, 9'(i / 2)};
            drive_scan(35, 216 + i, da);
            tick();
            if ((i % 2) == 0) begin
                checks++;
                if (bus.Mem_Addr !== da || bus.Mem_We !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_read col=%0d: addr=%h we=%b want addr=%h we=0",
                             216 + i, bus.Mem_Addr, bus.Mem_We, da);
                end
            end
            if (pix_q.size() >= 3) begin
                e = pix_q.pop_front();
                checks++;
                if (bus.Pix_Data !== e.data || bus.Pix_Valid !== e.valid) begin
                    errors++;
                    $display("FAIL scan_pix i=%0d: got valid=%b data=%h want valid=%b data=%h",
                             i, bus.Pix_Valid, bus.Pix_Data, e.valid, e.data);
                end
            end
        end
    endtask

    task automatic test_blank_write();
        int  n_ack;
        logic prev_ack;
        wr_t e;
        idle(2);
        for (int i = 0; i < 3; i++) wr_q.push_back('{addr: 17'd5, data: 8'hA5, err: 1'b0});
        n_ack = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.Wr_Req  = 1'b1;
            bus.Wr_Addr = 17'd5;
            bus.Wr_Data = 8'hA5;
            drive_scan(10, 100, 17'd0);
            tick();
            if (bus.Wr_Ack === 1'b1) begin
                n_ack++;
                checks++;
                if (prev_ack || wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL blank_b2b_or_extra cycle=%0d: prev_ack=%b pending=%0d want 0 and >0",
                             i, prev_ack, wr_q.size());
                end else begin
                    e = wr_q.pop_front();
                    if (bus.Mem_We !== 1'b1 || bus.Mem_Addr !== e.addr ||
                        bus.Mem_Din !== e.data || bus.Wr_Err !== e.err) begin
                        errors++;
                        $display("FAIL blank_write cycle=%0d: we=%b addr=%h din=%h err=%b want 1 %h %h %b",
                                 i, bus.Mem_We, bus.Mem_Addr, bus.Mem_Din, bus.Wr_Err, e.addr, e.data, e.err);
                    end
                end
            end else begin
                checks++;
                if (bus.Mem_We !== 1'b0) begin
                    errors++;
                    $display("FAIL blank_we_without_ack cycle=%0d: we=%b want 0", i, bus.Mem_We);
                end
            end
            prev_ack = bus.Wr_Ack;
        end
        bus.Wr_Req = 1'b0;
        tick();
        checks++;
        if (n_ack != 3 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL blank_count: acks=%0d want 3", n_ack);
        end
        wr_q.delete();
    endtask

    task automatic test_contention();
        logic [16:0] waddr;
        logic [16:0] da;
        logic [7:0]  wdata;
        logic        change, exp_ack, exp_ack_prev, disp, win;
        int          widx, n_ack;
        pix_t        e;
        idle(2);
        widx = 0;
        waddr = 17'd0;
        wdata = 8'h40;
        change = 1'b0;
        exp_ack_prev = 1'b0;
        n_ack = 0;
        for (int c = 216; c <= 900; c++) begin
            if (change) begin
                widx++;
                waddr = {8'(widx / 320), 9'(widx % 320)};
                wdata = wdata + 8'd1;
                change = 1'b0;
            end
            if (bus.Wr_Ack === 1'b1) change = 1'b1;
            win  = tb_win(35, c);
            disp = win && (((c - 216) % 2) == 0);
            da   = win ? {8'd0, 9'((c - 216) / 2)} : 17'd0;
            drive_scan(35, c, da);
            bus.Wr_Req  = 1'b1;
            bus.Wr_Addr = waddr;
            bus.Wr_Data = wdata;
            exp_ack = !disp && !exp_ack_prev;
            exp_ack_prev = exp_ack;
            tick();
            checks++;
            if (disp) begin
                if (bus.Wr_Ack !== 1'b0 || bus.Mem_We !== 1'b0 || bus.Mem_Addr !== da) begin
                    errors++;
                    $display("FAIL cont_disp col=%0d: ack=%b we=%b addr=%h want 0 0 %h",
                             c, bus.Wr_Ack, bus.Mem_We, bus.Mem_Addr, da);
                end
            end else if (exp_ack) begin
                if (bus.Wr_Ack !== 1'b1 || bus.Mem_We !== 1'b1 ||
                    bus.Mem_Addr !== waddr || bus.Mem_Din !== wdata) begin
                    errors++;
                    $display("FAIL cont_write col=%0d: ack=%b we=%b addr=%h din=%h want 1 1 %h %h",
                             c, bus.Wr_Ack, bus.Mem_We, bus.Mem_Addr, bus.Mem_Din, waddr, wdata);
                end
            end else begin
                if (bus.Wr_Ack !== 1'b0 || bus.Mem_We !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_idle col=%0d: ack=%b we=%b want 0 0", c, bus.Wr_Ack, bus.Mem_We);
                end
            end
            if (bus.Wr_Ack === 1'b1 && win) n_ack++;
            if (pix_q.size() >= 3) begin
                e = pix_q.pop_front();
                checks++;
                if (bus.Pix_Data !== e.data || bus.Pix_Valid !== e.valid) begin
                    errors++;
                    $display("FAIL cont_pix col=%0d: got valid=%b data=%h want valid=%b data=%h",
                             c, bus.Pix_Valid, bus.Pix_Data, e.valid, e.data);
                end
            end
        end
        bus.Wr_Req = 1'b0;
        tick();
        checks++;
        if (n_ack != 320) begin
            errors++;
            $display("FAIL cont_ack_count: got %0d want 320", n_ack);
        end
    endtask

    task automatic test_range();
        logic [16:0] ra [3];
        logic [7:0]  rd [3];
        logic        re [3];
        logic        got;
        wr_t         e;
        ra[0] = {8'd240, 9'd0};   rd[0] = 8'h5A; re[0] = 1'b1;
        ra[1] = {8'd0, 9'd320};   rd[1] = 8'h3C; re[1] = 1'b1;
        ra[2] = {8'd239, 9'd319}; rd[2] = 8'hC3; re[2] = 1'b0;
        idle(2);
        for (int k = 0; k < 3; k++) begin
            wr_q.push_back('{addr: ra[k], data: rd[k], err: re[k]});
            bus.Wr_Req  = 1'b1;
            bus.Wr_Addr = ra[k];
            bus.Wr_Data = rd[k];
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                drive_scan(10, 100, 17'd0);
                tick();
                if (bus.Wr_Ack === 1'b1) begin
                    got = 1'b1;
                    e = wr_q.pop_front();
                    checks++;
                    if (bus.Wr_Err !== e.err || bus.Mem_We !== !e.err || bus.Mem_Addr !== e.addr ||
                        (!e.err && bus.Mem_Din !== e.data)) begin
                        errors++;
                        $display("FAIL range k=%0d: err=%b we=%b addr=%h din=%h want err=%b we=%b addr=%h din=%h",
                                 k, bus.Wr_Err, bus.Mem_We, bus.Mem_Addr, bus.Mem_Din,
                                 e.err, !e.err, e.addr, e.data);
                    end
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL range_timeout k=%0d: ack=0 want 1 within 4 edges", k);
            end
            tick();
        end
        bus.Wr_Req = 1'b0;
        tick();
        wr_q.delete();
    endtask

    task automatic test_window_edge();
        logic [16:0] da;
        pix_t e;
        idle(2);
        for (int c = 850; c <= 862; c++) begin
            da = tb_win(35, c) ? {8'd0, 9'((c - 216) / 2)} : 17'd0;
            drive_scan(35, c, da);
            tick();
            if (pix_q.size() >= 3) begin
                e = pix_q.pop_front();
                checks++;
                if (bus.Pix_Data !== e.data || bus.Pix_Valid !== e.valid) begin
                    errors++;
                    $display("FAIL edge_pix col=%0d: got valid=%b data=%h want valid=%b data=%h",
                             c - 2, bus.Pix_Valid, bus.Pix_Data, e.valid, e.data);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scanout();
        test_blank_write();
        test_contention();
        test_range();
        test_window_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
